// File: rtl/ysyx_22040237_imem_responder.sv
// Instruction-memory responder: accepts a fetch PC, waits LATENCY cycles, then returns
// the instruction word (or an error) through a valid/ready response channel.
module ysyx_22040237_imem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_inst,
  output logic                     rsp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  generate
    if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
      $error("LATENCY must be in the range 1..16");
    end
    if ((1 << AW) != DEPTH) begin : g_bad_depth
      $error("DEPTH must be a power of 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  logic [31:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_inst_q, rsp_inst_d;
  logic        rsp_err_q, rsp_err_d;

  logic        fire;
  logic        capture;
  logic [31:0] cap_addr;
  logic [31:0] cap_idx;
  logic        cap_err;

  assign req_ready = (state_q == IDLE) | ((state_q == RESP) & rsp_ready);
  assign fire      = req_valid & req_ready;

  assign rsp_valid = rsp_valid_q;
  assign rsp_inst  = rsp_inst_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    capture  = 1'b0;
    cap_addr = addr_q;
    // A fire can only happen in IDLE or in RESP with rsp_ready, so it takes priority.
    if (fire) begin
      addr_d = req_addr;
      if (LATENCY == 1) begin
        state_d  = RESP;
        capture  = 1'b1;
        cap_addr = req_addr;
      end else begin
        state_d = WAIT;
        cnt_d   = 4'(LATENCY - 2);
      end
    end else if (state_q == WAIT) begin
      if (cnt_q == '0) begin
        state_d = RESP;
        capture = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
    end

    cap_idx = (cap_addr - BASE_ADDR) >> 2;
    cap_err = (cap_addr[1:0] != 2'b00) | (cap_idx >= DEPTH);

    rsp_valid_d = (state_d == RESP);
    rsp_inst_d  = rsp_inst_q;
    rsp_err_d   = rsp_err_q;
    if (capture) begin
      rsp_err_d  = cap_err;
      rsp_inst_d = cap_err ? '0 : mem[cap_idx[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_inst_q  <= rsp_inst_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Memory is not reset; the capture above reads the pre-write value on a same-edge load.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_imem_responder.sv
// Scoreboard bench: one responder at LATENCY=1 and one at LATENCY=3 share clock, reset
// and load port; each has its own expected-response queue and monitor.
module tb_ysyx_22040237_imem_responder;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_err1;
  logic [31:0] req_addr1, rsp_inst1;
  logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_err3;
  logic [31:0] req_addr3, rsp_inst3;

  exp_t q1[$];
  exp_t q3[$];
  int   checks;
  int   errors;

  ysyx_22040237_imem_responder #(
    .DEPTH    (1024),
    .BASE_ADDR(32'h8000_0000),
    .LATENCY  (1)
  ) dut1 (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid1),
    .req_ready(req_ready1),
    .req_addr (req_addr1),
    .rsp_valid(rsp_valid1),
    .rsp_ready(rsp_ready1),
    .rsp_inst (rsp_inst1),
    .rsp_err  (rsp_err1),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  ysyx_22040237_imem_responder #(
    .DEPTH    (1024),
    .BASE_ADDR(32'h8000_0000),
    .LATENCY  (3)
  ) dut3 (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid3),
    .req_ready(req_ready3),
    .req_addr (req_addr3),
    .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3),
    .rsp_inst (rsp_inst3),
    .rsp_err  (rsp_err3),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid1 && rsp_ready1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("dut1_inst", rsp_inst1, e.inst);
        chk("dut1_err", {31'd0, rsp_err1}, {31'd0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid3 && rsp_ready3) begin
      if (q3.size() == 0) begin
        chk("dut3_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = q3.pop_front();
        chk("dut3_inst", rsp_inst3, e.inst);
        chk("dut3_err", {31'd0, rsp_err3}, {31'd0, e.err});
      end
    end
  end

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  // Issue one request; returns 1 time unit after the accepting edge.
  task automatic send(input int d, input logic [31:0] a, input logic [31:0] ei,
                      input logic ee, input bit push);
    exp_t e;
    bit   ok;
    e.inst = ei;
    e.err  = ee;
    ok     = 1'b0;
    if (d == 1) begin
      req_valid1 = 1'b1;
      req_addr1  = a;
      if (push) q1.push_back(e);
    end else begin
      req_valid3 = 1'b1;
      req_addr3  = a;
      if (push) q3.push_back(e);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((d == 1) ? req_ready1 : req_ready3) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    req_valid3 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    ld_en      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    req_valid1 = 1'b0;
    req_addr1  = '0;
    rsp_ready1 = 1'b1;
    req_valid3 = 1'b0;
    req_addr3  = '0;
    rsp_ready3 = 1'b1;

    #1;
    chk("rst_rsp_valid1", {31'd0, rsp_valid1}, 32'd0);
    chk("rst_rsp_inst1", rsp_inst1, 32'd0);
    chk("rst_rsp_err1", {31'd0, rsp_err1}, 32'd0);
    chk("rst_req_ready1", {31'd0, req_ready1}, 32'd1);
    chk("rst_rsp_valid3", {31'd0, rsp_valid3}, 32'd0);
    chk("rst_rsp_inst3", rsp_inst3, 32'd0);
    chk("rst_req_ready3", {31'd0, req_ready3}, 32'd1);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    load(10'd0, 32'h0010_0093);
    load(10'd1, 32'h0000_0513);
    load(10'd2, 32'h0020_0113);
    load(10'd3, 32'h00A0_0193);
    load(10'd1023, 32'hDEAD_BEEF);

    // LATENCY=1 single fetch: valid in the cycle right after the accept.
    send(1, 32'h8000_0000, 32'h0010_0093, 1'b0, 1'b1);
    @(negedge clk);
    chk("lat1_valid", {31'd0, rsp_valid1}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back, one accept and one response per cycle.
    q1.push_back('{inst: 32'h0010_0093, err: 1'b0});
    q1.push_back('{inst: 32'h0000_0513, err: 1'b0});
    q1.push_back('{inst: 32'h0020_0113, err: 1'b0});
    req_valid1 = 1'b1;
    req_addr1  = 32'h8000_0000;
    @(negedge clk);
    chk("b2b_ready0", {31'd0, req_ready1}, 32'd1);
    @(posedge clk);
    #1;
    req_addr1 = 32'h8000_0004;
    @(negedge clk);
    chk("b2b_valid0", {31'd0, rsp_valid1}, 32'd1);
    chk("b2b_ready1", {31'd0, req_ready1}, 32'd1);
    @(posedge clk);
    #1;
    req_addr1 = 32'h8000_0008;
    @(negedge clk);
    chk("b2b_valid1", {31'd0, rsp_valid1}, 32'd1);
    chk("b2b_ready2", {31'd0, req_ready1}, 32'd1);
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    @(negedge clk);
    chk("b2b_valid2", {31'd0, rsp_valid1}, 32'd1);
    @(posedge clk);
    #1;

    // Error and boundary addresses.
    send(1, 32'h8000_0002, 32'h0, 1'b1, 1'b1);
    send(1, 32'h7FFF_FFFC, 32'h0, 1'b1, 1'b1);
    send(1, 32'h8000_1000, 32'h0, 1'b1, 1'b1);
    send(1, 32'h8000_0FFC, 32'hDEAD_BEEF, 1'b0, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1;

    // Stall in RESP for 5 cycles with a competing request pending.
    rsp_ready1 = 1'b0;
    send(1, 32'h8000_0008, 32'h0020_0113, 1'b0, 1'b1);
    req_valid1 = 1'b1;
    req_addr1  = 32'h8000_000C;
    q1.push_back('{inst: 32'h00A0_0193, err: 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp_valid1}, 32'd1);
      chk("stall_inst", rsp_inst1, 32'h0020_0113);
      chk("stall_err", {31'd0, rsp_err1}, 32'd0);
      chk("stall_req_ready", {31'd0, req_ready1}, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready1 = 1'b1;
    @(negedge clk);
    chk("unstall_req_ready", {31'd0, req_ready1}, 32'd1);
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    @(negedge clk);
    chk("unstall_next_valid", {31'd0, rsp_valid1}, 32'd1);
    @(posedge clk);
    #1;

    // Load to the word being captured on the same edge: old data returned.
    req_valid1 = 1'b1;
    req_addr1  = 32'h8000_0008;
    ld_en      = 1'b1;
    ld_addr    = 10'd2;
    ld_data    = 32'h1234_5678;
    q1.push_back('{inst: 32'h0020_0113, err: 1'b0});
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    ld_en      = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    send(1, 32'h8000_0008, 32'h1234_5678, 1'b0, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1;

    // LATENCY=3: valid on the third cycle after the accept edge, req_ready low in WAIT.
    send(3, 32'h8000_0004, 32'h0000_0513, 1'b0, 1'b1);
    @(negedge clk);
    chk("lat3_c1_valid", {31'd0, rsp_valid3}, 32'd0);
    chk("lat3_c1_ready", {31'd0, req_ready3}, 32'd0);
    @(negedge clk);
    chk("lat3_c2_valid", {31'd0, rsp_valid3}, 32'd0);
    chk("lat3_c2_ready", {31'd0, req_ready3}, 32'd0);
    @(negedge clk);
    chk("lat3_c3_valid", {31'd0, rsp_valid3}, 32'd1);
    @(posedge clk);
    #1;

    // Reset while in WAIT drops the request; memory survives.
    send(3, 32'h8000_000C, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstwait_valid", {31'd0, rsp_valid3}, 32'd0);
    chk("rstwait_inst", rsp_inst3, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstwait_after_valid", {31'd0, rsp_valid3}, 32'd0);
      chk("rstwait_after_ready", {31'd0, req_ready3}, 32'd1);
    end
    @(posedge clk);
    #1;
    send(3, 32'h8000_0000, 32'h0010_0093, 1'b0, 1'b1);

    for (int i = 0; i < 20 && (q1.size() != 0 || q3.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
